// File: rtl/rot_unit.sv
// ============================================================================
// Module      : rot_unit
// Description : 32-bit rotate-and-mask / shift unit with a valid/ready result
//               register. Defining ROT_UNIT_INPUT_REG_EN adds an input stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rot_unit_pkg;
    typedef struct packed {
        logic [4:0] MB;
        logic [4:0] ME;
        logic       mask_insert;
        logic       shift;
        logic       left;
        logic       sign_extend;
        logic       alter_CR0;
    } rotate_decode_t;

    typedef struct packed {
        logic LT;
        logic GT;
        logic EQ;
        logic CR0_valid;
        logic CA;
        logic CA_valid;
    } cond_exception_t;
endpackage

module rot_unit
    import rot_unit_pkg::*;
#(
    parameter int RS_ID_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [RS_ID_WIDTH-1:0] rs_id_in,
    input  logic [4:0]             result_reg_addr_in,
    input  logic [31:0]            op1,
    input  logic [31:0]            op2,
    input  logic [31:0]            target,
    input  rotate_decode_t         control,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic [RS_ID_WIDTH-1:0] rs_id_out,
    output logic [4:0]             result_reg_addr_out,
    output logic [31:0]            result,
    output cond_exception_t        cr0_xer
);

    // Operands presented to the compute stage
    logic                   w_s_valid;
    logic                   w_s_ready;
    logic                   w_s_fire;
    logic [RS_ID_WIDTH-1:0] w_s_id;
    logic [4:0]             w_s_addr;
    logic [31:0]            w_s_op1;
    logic [31:0]            w_s_op2;
    logic [31:0]            w_s_target;
    rotate_decode_t         w_s_ctrl;

    logic                   r_out_valid;
    logic [RS_ID_WIDTH-1:0] r_out_id;
    logic [4:0]             r_out_addr;
    logic [31:0]            r_out_result;
    cond_exception_t        r_out_cr;

    assign w_s_ready = !r_out_valid || output_ready;
    assign w_s_fire  = w_s_valid && w_s_ready;

`ifdef ROT_UNIT_INPUT_REG_EN
    logic                   r_in_valid;
    logic [RS_ID_WIDTH-1:0] r_in_id;
    logic [4:0]             r_in_addr;
    logic [31:0]            r_in_op1;
    logic [31:0]            r_in_op2;
    logic [31:0]            r_in_target;
    rotate_decode_t         r_in_ctrl;

    assign input_ready = !r_in_valid || w_s_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_valid  <= 1'b0;
            r_in_id     <= '0;
            r_in_addr   <= '0;
            r_in_op1    <= '0;
            r_in_op2    <= '0;
            r_in_target <= '0;
            r_in_ctrl   <= '0;
        end else if (input_ready) begin
            r_in_valid <= input_valid;
            if (input_valid) begin
                r_in_id     <= rs_id_in;
                r_in_addr   <= result_reg_addr_in;
                r_in_op1    <= op1;
                r_in_op2    <= op2;
                r_in_target <= target;
                r_in_ctrl   <= control;
            end
        end
    end

    assign w_s_valid  = r_in_valid;
    assign w_s_id     = r_in_id;
    assign w_s_addr   = r_in_addr;
    assign w_s_op1    = r_in_op1;
    assign w_s_op2    = r_in_op2;
    assign w_s_target = r_in_target;
    assign w_s_ctrl   = r_in_ctrl;
`else
    assign input_ready = w_s_ready;
    assign w_s_valid   = input_valid;
    assign w_s_id      = rs_id_in;
    assign w_s_addr    = result_reg_addr_in;
    assign w_s_op1     = op1;
    assign w_s_op2     = op2;
    assign w_s_target  = target;
    assign w_s_ctrl    = control;
`endif

    // Only the low six bits of op2 ever select an amount
    logic w_unused_op2;
    assign w_unused_op2 = ^w_s_op2[31:6];

    logic [63:0]     w_dbl;
    logic [31:0]     w_rot;
    logic [31:0]     w_m_lo;
    logic [31:0]     w_m_hi;
    logic [31:0]     w_mask;
    logic [31:0]     w_shout;
    logic [5:0]      w_n;
    logic [31:0]     w_res;
    cond_exception_t w_cr;

    // IBM bit i is vector bit 31-i, so op2[27:31] is op2[4:0]
    always_comb begin
        w_n     = w_s_op2[5:0];
        w_dbl   = {w_s_op1, w_s_op1} << w_s_op2[4:0];
        w_rot   = w_dbl[63:32];
        w_m_lo  = 32'hFFFF_FFFF >> w_s_ctrl.MB;
        w_m_hi  = ~(32'h7FFF_FFFF >> w_s_ctrl.ME);
        w_mask  = (w_s_ctrl.MB <= w_s_ctrl.ME) ? (w_m_lo & w_m_hi) : (w_m_lo | w_m_hi);
        w_shout = w_n[5] ? 32'hFFFF_FFFF : ~(32'hFFFF_FFFF << w_n[4:0]);
        w_res   = '0;
        w_cr    = '0;
        if (!w_s_ctrl.shift) begin
            w_res = w_s_ctrl.mask_insert ? ((w_rot & w_mask) | (w_s_target & ~w_mask))
                                         : (w_rot & w_mask);
        end else if (w_s_ctrl.left) begin
            w_res = w_n[5] ? 32'h0 : (w_s_op1 << w_n[4:0]);
        end else if (!w_s_ctrl.sign_extend) begin
            w_res = w_n[5] ? 32'h0 : (w_s_op1 >> w_n[4:0]);
        end else begin
            w_res       = w_n[5] ? {32{w_s_op1[31]}} : 32'($signed(w_s_op1) >>> w_n[4:0]);
            w_cr.CA_valid = 1'b1;
            w_cr.CA       = w_s_op1[31] && (|(w_s_op1 & w_shout));
        end
        if (w_s_ctrl.alter_CR0) begin
            w_cr.CR0_valid = 1'b1;
            w_cr.LT        = w_res[31];
            w_cr.GT        = !w_res[31] && (|w_res);
            w_cr.EQ        = ~|w_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_id     <= '0;
            r_out_addr   <= '0;
            r_out_result <= '0;
            r_out_cr     <= '0;
        end else if (w_s_fire) begin
            r_out_valid  <= 1'b1;
            r_out_id     <= w_s_id;
            r_out_addr   <= w_s_addr;
            r_out_result <= w_res;
            r_out_cr     <= w_cr;
        end else if (output_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign output_valid        = r_out_valid;
    assign rs_id_out           = r_out_id;
    assign result_reg_addr_out = r_out_addr;
    assign result              = r_out_result;
    assign cr0_xer             = r_out_cr;

endmodule

`default_nettype wire

// File: tb/tb_rot_unit.sv
// ============================================================================
// Module      : tb_rot_unit
// Description : Directed self-checking bench for rot_unit (default build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rot_unit;
    import rot_unit_pkg::*;

    localparam int RS_ID_WIDTH = 5;

    logic                   clk;
    logic                   rst;
    logic                   input_valid;
    logic                   input_ready;
    logic [RS_ID_WIDTH-1:0] rs_id_in;
    logic [4:0]             result_reg_addr_in;
    logic [31:0]            op1;
    logic [31:0]            op2;
    logic [31:0]            target;
    rotate_decode_t         control;
    logic                   output_valid;
    logic                   output_ready;
    logic [RS_ID_WIDTH-1:0] rs_id_out;
    logic [4:0]             result_reg_addr_out;
    logic [31:0]            result;
    cond_exception_t        cr0_xer;

    int checks   = 0;
    int failures = 0;

    rot_unit #(.RS_ID_WIDTH(RS_ID_WIDTH)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .input_valid         (input_valid),
        .input_ready         (input_ready),
        .rs_id_in            (rs_id_in),
        .result_reg_addr_in  (result_reg_addr_in),
        .op1                 (op1),
        .op2                 (op2),
        .target              (target),
        .control             (control),
        .output_valid        (output_valid),
        .output_ready        (output_ready),
        .rs_id_out           (rs_id_out),
        .result_reg_addr_out (result_reg_addr_out),
        .result              (result),
        .cr0_xer             (cr0_xer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected results of the four reference operations
    logic [31:0] exp_std [4];
    initial begin
        exp_std[0] = 32'hFFFF_0BC8;
        exp_std[1] = 32'hE44C_8005;
        exp_std[2] = 32'h9900_0BC8;
        exp_std[3] = 32'h9900_00C8;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic cond_exception_t mk_cr(input logic lt, gt, eq, cv, ca, cav);
        cond_exception_t c;
        c.LT = lt; c.GT = gt; c.EQ = eq; c.CR0_valid = cv; c.CA = ca; c.CA_valid = cav;
        return c;
    endfunction

    task automatic set_op(input logic [31:0] a, b, t, input logic [4:0] mb, me,
                          input logic mi, sh, lf, se, cr);
        op1 = a; op2 = b; target = t;
        control.MB = mb; control.ME = me; control.mask_insert = mi;
        control.shift = sh; control.left = lf; control.sign_extend = se; control.alter_CR0 = cr;
    endtask

    task automatic load_std(input int k, input logic [4:0] id, input logic [4:0] addr);
        rs_id_in = id;
        result_reg_addr_in = addr;
        case (k)
            0:       set_op(32'h05E4_4C80, 32'd17, 32'hFFFF_0000, 5'd16, 5'd28, 1, 0, 0, 0, 1);
            1:       set_op(32'h05E4_4C80, 32'd8,  32'h0, 5'd0,  5'd31, 0, 0, 0, 0, 0);
            2:       set_op(32'h05E4_4C80, 32'd17, 32'h0, 5'd0,  5'd31, 0, 0, 0, 0, 0);
            default: set_op(32'h05E4_4C80, 32'd17, 32'h0, 5'd24, 5'd7,  0, 0, 0, 0, 0);
        endcase
    endtask

    task automatic test_reset();
        rst = 1'b1; output_ready = 1'b1;
        load_std(0, 5'd7, 5'd9);
        input_valid = 1'b1;
        tick(); tick();
        rst = 1'b0; input_valid = 1'b0;
        checks++;
        if (output_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%b exp=0", output_valid);
        end
        checks++;
        if ({rs_id_out, result_reg_addr_out, result} !== 42'h0) begin
            failures++;
            $display("FAIL reset_data got=%h/%h/%h exp=0", rs_id_out, result_reg_addr_out, result);
        end
        checks++;
        if (cr0_xer !== 6'b0) begin
            failures++; $display("FAIL reset_cr got=%b exp=000000", cr0_xer);
        end
        checks++;
        if (input_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready got=%b exp=1", input_ready);
        end
    endtask

    task automatic test_rotate();
        cond_exception_t ecr;
        for (int k = 0; k < 4; k++) begin
            load_std(k, 5'(k), 5'(20 + k));
            input_valid = 1'b1;
            tick();
            input_valid = 1'b0;
            ecr = (k == 0) ? mk_cr(1, 0, 0, 1, 0, 0) : mk_cr(0, 0, 0, 0, 0, 0);
            checks++;
            if (output_valid !== 1'b1 || result !== exp_std[k]) begin
                failures++;
                $display("FAIL rotate_%0d got v=%b r=%h exp v=1 r=%h", k, output_valid, result, exp_std[k]);
            end
            checks++;
            if (cr0_xer !== ecr) begin
                failures++; $display("FAIL rotate_cr_%0d got=%b exp=%b", k, cr0_xer, ecr);
            end
        end
        tick();
    endtask

    task automatic test_shift();
        logic [31:0]     a   [6];
        logic [5:0]      n   [6];
        logic [2:0]      mode[6];  // {left, sign_extend, alter_CR0}
        logic [31:0]     er  [6];
        cond_exception_t ec  [6];
        a[0] = 32'h05E4_4C80; n[0] = 6'd4;  mode[0] = 3'b100; er[0] = 32'h5E44_C800; ec[0] = mk_cr(0,0,0,0,0,0);
        a[1] = 32'h8000_0001; n[1] = 6'd1;  mode[1] = 3'b010; er[1] = 32'hC000_0000; ec[1] = mk_cr(0,0,0,0,1,1);
        a[2] = 32'h8000_0001; n[2] = 6'd32; mode[2] = 3'b010; er[2] = 32'hFFFF_FFFF; ec[2] = mk_cr(0,0,0,0,1,1);
        a[3] = 32'h8000_0001; n[3] = 6'd40; mode[3] = 3'b001; er[3] = 32'h0;         ec[3] = mk_cr(0,0,1,1,0,0);
        a[4] = 32'h8000_0010; n[4] = 6'd4;  mode[4] = 3'b011; er[4] = 32'hF800_0001; ec[4] = mk_cr(1,0,0,1,0,1);
        a[5] = 32'h0000_0013; n[5] = 6'd1;  mode[5] = 3'b011; er[5] = 32'h0000_0009; ec[5] = mk_cr(0,1,0,1,0,1);
        rs_id_in = 5'd5; result_reg_addr_in = 5'd3;
        for (int k = 0; k < 6; k++) begin
            set_op(a[k], {26'h3FF_FFC0 >> 6, n[k]}, 32'h0, 5'd9, 5'd3, 1, 1, mode[k][2], mode[k][1], mode[k][0]);
            input_valid = 1'b1;
            tick();
            input_valid = 1'b0;
            checks++;
            if (output_valid !== 1'b1 || result !== er[k] || cr0_xer !== ec[k]) begin
                failures++;
                $display("FAIL shift_%0d got v=%b r=%h cr=%b exp v=1 r=%h cr=%b",
                         k, output_valid, result, cr0_xer, er[k], ec[k]);
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        output_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            load_std(k, 5'(k), 5'(31 - k));
            input_valid = 1'b1;
            tick();
            checks++;
            if ({output_valid, rs_id_out, result_reg_addr_out, result} !==
                {1'b1, 5'(k), 5'(31 - k), exp_std[k]}) begin
                failures++;
                $display("FAIL b2b_%0d got v=%b id=%0d a=%0d r=%h exp id=%0d a=%0d r=%h",
                         k, output_valid, rs_id_out, result_reg_addr_out, result, k, 31 - k, exp_std[k]);
            end
        end
        input_valid = 1'b0;
        tick();
        checks++;
        if (output_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_drain got v=%b exp=0", output_valid);
        end
    endtask

    task automatic test_backpressure();
        output_ready = 1'b0;
        load_std(0, 5'd0, 5'd31);
        input_valid = 1'b1;
        tick();
        load_std(1, 5'd1, 5'd30);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({input_ready, output_valid, rs_id_out, result} !== {1'b0, 1'b1, 5'd0, exp_std[0]}) begin
                failures++;
                $display("FAIL stall_%0d got rdy=%b v=%b id=%0d r=%h exp rdy=0 v=1 id=0 r=%h",
                         c, input_ready, output_valid, rs_id_out, result, exp_std[0]);
            end
            tick();
        end
        checks++;
        if (output_valid !== 1'b1 || rs_id_out !== 5'd0) begin
            failures++; $display("FAIL stall_hold got v=%b id=%0d exp v=1 id=0", output_valid, rs_id_out);
        end
        output_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            load_std(k, 5'(k), 5'(31 - k));
            tick();
            checks++;
            if ({output_valid, rs_id_out, result} !== {1'b1, 5'(k), exp_std[k]}) begin
                failures++;
                $display("FAIL release_%0d got v=%b id=%0d r=%h exp v=1 id=%0d r=%h",
                         k, output_valid, rs_id_out, result, k, exp_std[k]);
            end
        end
        input_valid = 1'b0;
        tick();
        checks++;
        if (output_valid !== 1'b0) begin
            failures++; $display("FAIL release_drain got v=%b exp=0", output_valid);
        end
    endtask

    task automatic test_bubbles();
        logic       vin  [7];
        logic [4:0] tag  [7];
        logic       ev   [7];
        logic [4:0] etag [7];
        vin = '{1, 0, 1, 0, 0, 1, 0};
        tag = '{5'd12, 5'd0, 5'd13, 5'd0, 5'd0, 5'd11, 5'd0};
        ev  = '{1, 0, 1, 0, 0, 1, 0};
        etag = '{5'd12, 5'd12, 5'd13, 5'd13, 5'd13, 5'd11, 5'd11};
        output_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            load_std(1, tag[c], 5'd4);
            input_valid = vin[c];
            tick();
            checks++;
            if (output_valid !== ev[c] || (ev[c] && rs_id_out !== etag[c])) begin
                failures++;
                $display("FAIL bubble_%0d got v=%b id=%0d exp v=%b id=%0d",
                         c, output_valid, rs_id_out, ev[c], etag[c]);
            end
        end
        output_ready = 1'b0;
        load_std(2, 5'd9, 5'd6);
        input_valid = 1'b1;
        tick();
        input_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({output_valid, input_ready, result} !== {1'b0, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL mid_reset got v=%b rdy=%b r=%h exp v=0 rdy=1 r=0", output_valid, input_ready, result);
        end
    endtask

    initial begin
        rst = 1'b1; input_valid = 1'b0; output_ready = 1'b0;
        rs_id_in = '0; result_reg_addr_in = '0;
        op1 = '0; op2 = '0; target = '0; control = '0;
        @(negedge clk);
        test_reset();
        test_rotate();
        test_shift();
        test_back_to_back();
        test_backpressure();
        test_bubbles();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
